// File: rtl/arb_client_if.sv
// Job-queue handshake and arbiter request/grant bundle for arb_client.
// slave is the client's view; master is the job source / arbiter side.
interface arb_client_if;
  logic       job_valid;
  logic [3:0] job_len;
  logic       job_ready;
  logic       request;
  logic       grant;

  modport slave  (input  job_valid, job_len, grant, output job_ready, request);
  modport master (output job_valid, job_len, grant, input  job_ready, request);
endinterface

// File: rtl/arb_client.sv
// Requester-side client for a fixed-priority arbiter: queues transfer jobs,
// holds request until each job's beats are granted, and flags starvation.
module arb_client #(
  parameter int DEPTH    = 4,
  parameter int WAIT_MAX = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  arb_client_if.slave                bus,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       beat_o,
  output logic [3:0]                 beat_cnt_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       starve_o,
  input  logic                       starve_clr_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [7:0] WMAX = 8'(WAIT_MAX);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic [4:0]    remain_q, remain_d;
  logic [3:0]    beat_cnt_q, beat_cnt_d;
  logic [7:0]    wait_q, wait_d;
  logic          starve_q, starve_d;
  logic          job_ready, push, pop, beat;

  assign job_ready = (level_q != LW'(DEPTH));
  assign push      = bus.job_valid & job_ready;
  assign pop       = (state_q == IDLE) && (level_q != '0);
  // A grant seen while not requesting is the arbiter's trailing grant.
  assign beat      = (state_q == REQ) & bus.grant;

  assign bus.job_ready = job_ready;
  assign bus.request   = (state_q == REQ);
  assign level_o       = level_q;
  assign beat_o        = beat;
  assign beat_cnt_o    = beat_cnt_q;
  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == GAP);
  assign starve_o      = starve_q;

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (!push && pop) begin
      level_d = level_q - LW'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    remain_d   = remain_q;
    beat_cnt_d = beat_cnt_q;
    wait_d     = '0;
    starve_d   = starve_q & ~starve_clr_i;
    case (state_q)
      IDLE: begin
        if (pop) begin
          remain_d   = {1'b0, mem_q[rd_ptr_q]} + 5'd1;
          beat_cnt_d = '0;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (beat) begin
          remain_d   = remain_q - 5'd1;
          beat_cnt_d = beat_cnt_q + 4'd1;
          if (remain_q == 5'd1) begin
            state_d = GAP;
          end
        end else begin
          // Saturating un-granted count; starve sets only on reaching the limit.
          wait_d = (wait_q == WMAX) ? wait_q : wait_q + 8'd1;
          if (wait_q == WMAX - 8'd1) begin
            starve_d = 1'b1;
          end
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.job_len;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      remain_q   <= '0;
      beat_cnt_q <= '0;
      wait_q     <= '0;
      starve_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      remain_q   <= remain_d;
      beat_cnt_q <= beat_cnt_d;
      wait_q     <= wait_d;
      starve_q   <= starve_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_arb_client.sv
// Bench for arb_client: a registered arbiter model supplies grant, and a job
// scoreboard checks beat count and beat_cnt on every done pulse.
module tb_arb_client;
  localparam int DEPTH    = 4;
  localparam int WAIT_MAX = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       starve_clr;
  logic [2:0] level;
  logic       beat;
  logic [3:0] beat_cnt;
  logic       busy;
  logic       done;
  logic       starve;
  logic       hp_block;

  int total = 0;
  int bad   = 0;
  int sb[$];
  int done_count = 0;
  int beats_seen = 0;

  arb_client_if bus ();

  arb_client #(.DEPTH(DEPTH), .WAIT_MAX(WAIT_MAX)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .level_o      (level),
    .beat_o       (beat),
    .beat_cnt_o   (beat_cnt),
    .busy_o       (busy),
    .done_o       (done),
    .starve_o     (starve),
    .starve_clr_i (starve_clr)
  );

  always #5 clk = ~clk;

  // Arbiter model: grant is the registered request, withheld while the
  // higher-priority requester owns the bus.
  always @(posedge clk or posedge rst) begin
    if (rst) bus.grant <= 1'b0;
    else     bus.grant <= bus.request & ~hp_block;
  end

  // Scoreboard: each done pops one expected job length.
  always @(negedge clk) begin
    if (rst) begin
      beats_seen = 0;
    end else begin
      if (beat === 1'b1) beats_seen++;
      if (done === 1'b1) begin
        int exp_len;
        done_count++;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected_done: got done=1, required no done (no job expected)");
        end else begin
          exp_len = sb.pop_front();
          if (beats_seen != exp_len + 1) begin
            bad++;
            $display("FAIL sb_beats: got %0d beats, required %0d", beats_seen, exp_len + 1);
          end
          total++;
          if (beat_cnt !== 4'(exp_len + 1)) begin
            bad++;
            $display("FAIL sb_beat_cnt: got %0d, required %0d", beat_cnt, 4'(exp_len + 1));
          end
        end
        $display("job done: beats=%0d beat_cnt=%0d", beats_seen, beat_cnt);
        beats_seen = 0;
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      cycle();
      if (busy === 1'b0 && level === 3'd0) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_idle_timeout: got busy=%0b level=%0d, required idle", tag, busy, level);
    end
  endtask

  task automatic wait_done(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_done_timeout: got no done, required done", tag);
    end
  endtask

  task automatic test_reset();
    int req_hi = 0;
    total++;
    if ({bus.request, done, starve, beat_cnt, busy, level, bus.job_ready, beat} !== 14'b0_0_0_0000_0_000_1_0) begin
      bad++;
      $display("FAIL reset_state: got req=%0b done=%0b starve=%0b cnt=%0d busy=%0b level=%0d ready=%0b beat=%0b, required 0,0,0,0,0,0,1,0",
               bus.request, done, starve, beat_cnt, busy, level, bus.job_ready, beat);
    end
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (bus.request !== 1'b0) req_hi++;
    end
    total++;
    if (req_hi != 0) begin
      bad++;
      $display("FAIL reset_idle_request: got %0d request cycles, required 0", req_hi);
    end
    $display("test_reset: checked");
  endtask

  task automatic test_single();
    logic exp_req, exp_beat, exp_done;
    hp_block = 1'b0;
    cycle();
    bus.job_valid = 1'b1; bus.job_len = 4'd2; sb.push_back(2);
    for (int c = 1; c <= 7; c++) begin
      cycle();
      bus.job_valid = 1'b0;
      exp_req  = (c >= 2 && c <= 5);
      exp_beat = (c >= 3 && c <= 5);
      exp_done = (c == 6);
      total++;
      if (bus.request !== exp_req) begin
        bad++;
        $display("FAIL single_request_c%0d: got %0b, required %0b", c, bus.request, exp_req);
      end
      total++;
      if (beat !== exp_beat) begin
        bad++;
        $display("FAIL single_beat_c%0d: got %0b, required %0b", c, beat, exp_beat);
      end
      total++;
      if (done !== exp_done) begin
        bad++;
        $display("FAIL single_done_c%0d: got %0b, required %0b", c, done, exp_done);
      end
      if (c == 1) begin
        total++;
        if (level !== 3'd1) begin
          bad++;
          $display("FAIL single_level_c1: got %0d, required 1", level);
        end
      end
      if (c >= 6) begin
        total++;
        if (beat_cnt !== 4'd3) begin
          bad++;
          $display("FAIL single_beat_cnt_c%0d: got %0d, required 3", c, beat_cnt);
        end
      end
    end
    wait_idle("single");
    $display("test_single: checked");
  endtask

  task automatic test_back_to_back();
    int lens [5] = '{1, 0, 2, 1, 3};
    int d0;
    hp_block = 1'b1;
    cycle();
    bus.job_valid = 1'b1; bus.job_len = 4'd15; sb.push_back(15);
    cycle();
    bus.job_valid = 1'b0;
    cycle();
    cycle();
    d0 = done_count;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (level !== 3'(i) || bus.job_ready !== (i < DEPTH)) begin
        bad++;
        $display("FAIL b2b_push%0d: got level=%0d ready=%0b, required level=%0d ready=%0b",
                 i, level, bus.job_ready, i, (i < DEPTH));
      end
      bus.job_valid = 1'b1;
      bus.job_len   = 4'(lens[i]);
      if (i < DEPTH) sb.push_back(lens[i]);
      cycle();
    end
    bus.job_valid = 1'b0;
    total++;
    if (level !== 3'd4 || bus.job_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_full: got level=%0d ready=%0b, required level=4 ready=0", level, bus.job_ready);
    end
    hp_block = 1'b0;
    wait_idle("b2b");
    total++;
    if (done_count - d0 != 5) begin
      bad++;
      $display("FAIL b2b_done_count: got %0d, required 5 (active + 4 queued)", done_count - d0);
    end
    total++;
    if (level !== 3'd0) begin
      bad++;
      $display("FAIL b2b_level_end: got %0d, required 0", level);
    end
    starve_clr = 1'b1;
    cycle();
    starve_clr = 1'b0;
    $display("test_back_to_back: checked");
  endtask

  task automatic test_preempt();
    int d0 = done_count;
    hp_block = 1'b0;
    cycle();
    bus.job_valid = 1'b1; bus.job_len = 4'd3; sb.push_back(3);
    for (int c = 1; c <= 11; c++) begin
      cycle();
      bus.job_valid = 1'b0;
      if (c == 4) hp_block = 1'b1;
      if (c == 7) hp_block = 1'b0;
      if (c >= 5 && c <= 7) begin
        total++;
        if (bus.request !== 1'b1 || beat !== 1'b0 || beat_cnt !== 4'd2) begin
          bad++;
          $display("FAIL preempt_hold_c%0d: got req=%0b beat=%0b cnt=%0d, required req=1 beat=0 cnt=2",
                   c, bus.request, beat, beat_cnt);
        end
      end
      if (c == 10) begin
        total++;
        if (done !== 1'b1 || beat_cnt !== 4'd4) begin
          bad++;
          $display("FAIL preempt_done_c10: got done=%0b cnt=%0d, required done=1 cnt=4", done, beat_cnt);
        end
      end
    end
    total++;
    if (done_count - d0 != 1) begin
      bad++;
      $display("FAIL preempt_done_count: got %0d, required 1", done_count - d0);
    end
    wait_idle("preempt");
    $display("test_preempt: checked");
  endtask

  task automatic test_starve();
    hp_block = 1'b1;
    cycle();
    bus.job_valid = 1'b1; bus.job_len = 4'd0; sb.push_back(0);
    for (int c = 1; c <= 11; c++) begin
      cycle();
      bus.job_valid = 1'b0;
      if (c == 9 || c == 10) begin
        total++;
        if (starve !== (c == 10)) begin
          bad++;
          $display("FAIL starve_set_c%0d: got %0b, required %0b", c, starve, (c == 10));
        end
      end
    end
    hp_block = 1'b0;
    wait_done("starve");
    cycle();
    cycle();
    total++;
    if (starve !== 1'b1) begin
      bad++;
      $display("FAIL starve_sticky: got %0b, required 1", starve);
    end
    starve_clr = 1'b1;
    cycle();
    starve_clr = 1'b0;
    total++;
    if (starve !== 1'b0) begin
      bad++;
      $display("FAIL starve_clear: got %0b, required 0", starve);
    end
    hp_block = 1'b1;
    starve_clr = 1'b1;
    cycle();
    bus.job_valid = 1'b1; bus.job_len = 4'd0; sb.push_back(0);
    for (int c = 1; c <= 10; c++) begin
      cycle();
      bus.job_valid = 1'b0;
      if (c == 9 || c == 10) begin
        total++;
        if (starve !== (c == 10)) begin
          bad++;
          $display("FAIL starve_set_wins_c%0d: got %0b, required %0b", c, starve, (c == 10));
        end
      end
    end
    starve_clr = 1'b0;
    hp_block = 1'b0;
    wait_idle("starve2");
    starve_clr = 1'b1;
    cycle();
    starve_clr = 1'b0;
    $display("test_starve: checked");
  endtask

  task automatic test_rst_midjob();
    int d0;
    int done_hi = 0;
    hp_block = 1'b0;
    cycle();
    bus.job_valid = 1'b1; bus.job_len = 4'd3; sb.push_back(3);
    cycle();
    bus.job_len = 4'd1;
    cycle();
    bus.job_valid = 1'b0;
    cycle();
    cycle();
    cycle();
    total++;
    if (beat_cnt !== 4'd2 || level !== 3'd1) begin
      bad++;
      $display("FAIL rst_pre: got cnt=%0d level=%0d, required cnt=2 level=1", beat_cnt, level);
    end
    d0 = done_count;
    rst = 1'b1;
    sb.delete();
    #1;
    total++;
    if (bus.request !== 1'b0 || level !== 3'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_async: got req=%0b level=%0d busy=%0b, required 0,0,0", bus.request, level, busy);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (done !== 1'b0 || bus.request !== 1'b0) done_hi++;
    end
    total++;
    if (done_hi != 0 || done_count != d0) begin
      bad++;
      $display("FAIL rst_no_done: got %0d active cycles, required 0", done_hi);
    end
    bus.job_valid = 1'b1; bus.job_len = 4'd1; sb.push_back(1);
    cycle();
    bus.job_valid = 1'b0;
    wait_done("rst_after");
    total++;
    if (beat_cnt !== 4'd2) begin
      bad++;
      $display("FAIL rst_after_cnt: got %0d, required 2", beat_cnt);
    end
    wait_idle("rst_after");
    $display("test_rst_midjob: checked");
  endtask

  initial begin
    rst = 1'b1;
    starve_clr = 1'b0;
    hp_block = 1'b0;
    bus.job_valid = 1'b0;
    bus.job_len = 4'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_preempt();
    test_starve();
    test_rst_midjob();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: got %0d pending jobs, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
